// File: rtl/pulse_measure.sv
// ---------------------------------------------------------------------------
// pulse_measure
//   Measures the high width and the rise-to-rise period of a single-bit pulse
//   stream. Each measurement is checked against an expected value within an
//   absolute tolerance. The block also keeps saturating error counters, a
//   wrapping pulse counter and a sticky counter-overflow flag.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   clr               synchronous clear, same effect as rst
//   pulse_in          monitored pulse (synchronous to clk)
//   exp_width         expected high width, 0 disables the width check
//   exp_period        expected period, 0 disables the period check
//   tol               allowed absolute deviation for both checks
//   width_out/_vld    last width, one-cycle update strobe
//   period_out/_vld   last period, one-cycle update strobe
//   width_err         width measurement out of tolerance (qualifies width_vld)
//   period_err        period measurement out of tolerance (qualifies period_vld)
//   pulse_cnt         accepted rising edges, wraps
//   width_err_cnt     saturating count of width errors
//   period_err_cnt    saturating count of period errors
//   ovf               sticky, a width or period counter saturated
// ---------------------------------------------------------------------------
module pulse_measure #(
  parameter int CNT_W = 32,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] exp_width,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [7:0]       tol,
  output logic [CNT_W-1:0] width_out,
  output logic             width_vld,
  output logic [CNT_W-1:0] period_out,
  output logic             period_vld,
  output logic             width_err,
  output logic             period_err,
  output logic [31:0]      pulse_cnt,
  output logic [ERR_W-1:0] width_err_cnt,
  output logic [ERR_W-1:0] period_err_cnt,
  output logic             ovf
);

  typedef enum logic [1:0] {S_ARM, S_WAIT, S_HIGH, S_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             p_d1_q;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] width_out_q, width_out_d;
  logic [CNT_W-1:0] period_out_q, period_out_d;
  logic             width_vld_q, width_vld_d;
  logic             period_vld_q, period_vld_d;
  logic             width_err_q, width_err_d;
  logic             period_err_q, period_err_d;
  logic [31:0]      pulse_cnt_q, pulse_cnt_d;
  logic [ERR_W-1:0] width_err_cnt_q, width_err_cnt_d;
  logic [ERR_W-1:0] period_err_cnt_q, period_err_cnt_d;
  logic             ovf_q, ovf_d;

  logic             rise, fall, sync_clr;
  logic             wcnt_sat, pcnt_sat;
  logic [CNT_W-1:0] wcnt_inc, pcnt_inc;

  // rst and clr have identical effects, so rst dominating is automatic.
  assign sync_clr = rst | clr;
  assign rise     = pulse_in & ~p_d1_q;
  assign fall     = ~pulse_in & p_d1_q;

  // Saturating increments; a clamped increment is what raises ovf.
  assign wcnt_sat = (wcnt_q == CNT_MAX);
  assign pcnt_sat = (pcnt_q == CNT_MAX);
  assign wcnt_inc = wcnt_sat ? wcnt_q : wcnt_q + CNT_ONE;
  assign pcnt_inc = pcnt_sat ? pcnt_q : pcnt_q + CNT_ONE;

  // |meas - exp| > tol, difference taken as larger minus smaller.
  function automatic logic out_of_tol(input logic [CNT_W-1:0] meas,
                                      input logic [CNT_W-1:0] expv,
                                      input logic [7:0]       t);
    logic [CNT_W-1:0] diff;
    diff = (meas > expv) ? (meas - expv) : (expv - meas);
    return (expv != '0) && (diff > CNT_W'(t));
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (sync_clr) state_q <= S_ARM;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ARM:   if (!pulse_in) state_d = S_WAIT;
      S_WAIT:  if (rise)      state_d = S_HIGH;
      S_HIGH:  if (fall)      state_d = S_LOW;
      S_LOW:   if (rise)      state_d = S_HIGH;
      default:                state_d = S_ARM;
    endcase
  end

  // Datapath / output next-state logic
  always_comb begin
    wcnt_d           = wcnt_q;
    pcnt_d           = pcnt_q;
    width_out_d      = width_out_q;
    period_out_d     = period_out_q;
    width_vld_d      = 1'b0;
    period_vld_d     = 1'b0;
    width_err_d      = width_err_q;
    period_err_d     = period_err_q;
    pulse_cnt_d      = pulse_cnt_q;
    ovf_d            = ovf_q;

    // Error counters follow the registered strobe/flag pair.
    width_err_cnt_d  = width_err_cnt_q;
    period_err_cnt_d = period_err_cnt_q;
    if (width_vld_q && width_err_q && (width_err_cnt_q != ERR_MAX))
      width_err_cnt_d = width_err_cnt_q + ERR_W'(1);
    if (period_vld_q && period_err_q && (period_err_cnt_q != ERR_MAX))
      period_err_cnt_d = period_err_cnt_q + ERR_W'(1);

    case (state_q)
      S_WAIT: begin
        // First rise after arming: no period is available yet.
        if (rise) begin
          wcnt_d      = CNT_ONE;
          pcnt_d      = CNT_ONE;
          pulse_cnt_d = pulse_cnt_q + 32'd1;
        end
      end
      S_HIGH: begin
        // The falling sample is the first low cycle and belongs to the period.
        pcnt_d = pcnt_inc;
        if (pcnt_sat) ovf_d = 1'b1;
        if (fall) begin
          width_out_d = wcnt_q;
          width_vld_d = 1'b1;
          width_err_d = out_of_tol(wcnt_q, exp_width, tol);
        end else begin
          wcnt_d = wcnt_inc;
          if (wcnt_sat) ovf_d = 1'b1;
        end
      end
      S_LOW: begin
        if (rise) begin
          period_out_d = pcnt_q;
          period_vld_d = 1'b1;
          period_err_d = out_of_tol(pcnt_q, exp_period, tol);
          wcnt_d       = CNT_ONE;
          pcnt_d       = CNT_ONE;
          pulse_cnt_d  = pulse_cnt_q + 32'd1;
        end else begin
          pcnt_d = pcnt_inc;
          if (pcnt_sat) ovf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (sync_clr) begin
      // p_d1 starts high so a pulse already high is not seen as a rise.
      p_d1_q           <= 1'b1;
      wcnt_q           <= '0;
      pcnt_q           <= '0;
      width_out_q      <= '0;
      period_out_q     <= '0;
      width_vld_q      <= 1'b0;
      period_vld_q     <= 1'b0;
      width_err_q      <= 1'b0;
      period_err_q     <= 1'b0;
      pulse_cnt_q      <= '0;
      width_err_cnt_q  <= '0;
      period_err_cnt_q <= '0;
      ovf_q            <= 1'b0;
    end else begin
      p_d1_q           <= pulse_in;
      wcnt_q           <= wcnt_d;
      pcnt_q           <= pcnt_d;
      width_out_q      <= width_out_d;
      period_out_q     <= period_out_d;
      width_vld_q      <= width_vld_d;
      period_vld_q     <= period_vld_d;
      width_err_q      <= width_err_d;
      period_err_q     <= period_err_d;
      pulse_cnt_q      <= pulse_cnt_d;
      width_err_cnt_q  <= width_err_cnt_d;
      period_err_cnt_q <= period_err_cnt_d;
      ovf_q            <= ovf_d;
    end
  end

  assign width_out      = width_out_q;
  assign width_vld      = width_vld_q;
  assign period_out     = period_out_q;
  assign period_vld     = period_vld_q;
  assign width_err      = width_err_q;
  assign period_err     = period_err_q;
  assign pulse_cnt      = pulse_cnt_q;
  assign width_err_cnt  = width_err_cnt_q;
  assign period_err_cnt = period_err_cnt_q;
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_pulse_measure.sv
// ---------------------------------------------------------------------------
// tb_pulse_measure
//   Bench for pulse_measure. Instance A (32/16) is followed cycle by cycle by
//   a timestamp-based reference model. Instance B (8/4) exercises counter
//   saturation, ovf and error-counter saturation.
// ---------------------------------------------------------------------------
module tb_pulse_measure;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A
  logic        rst, clr, pulse_in;
  logic [31:0] exp_width, exp_period;
  logic [7:0]  tol;
  logic [31:0] width_out, period_out, pulse_cnt;
  logic        width_vld, period_vld, width_err, period_err, ovf;
  logic [15:0] width_err_cnt, period_err_cnt;

  // Instance B
  logic        rst_b, clr_b, pulse_b;
  logic [7:0]  exp_width_b, exp_period_b, tol_b;
  logic [7:0]  width_out_b, period_out_b;
  logic [31:0] pulse_cnt_b;
  logic        width_vld_b, period_vld_b, width_err_b, period_err_b, ovf_b;
  logic [3:0]  width_err_cnt_b, period_err_cnt_b;

  pulse_measure #(.CNT_W(32), .ERR_W(16)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .pulse_in(pulse_in),
    .exp_width(exp_width), .exp_period(exp_period), .tol(tol),
    .width_out(width_out), .width_vld(width_vld),
    .period_out(period_out), .period_vld(period_vld),
    .width_err(width_err), .period_err(period_err),
    .pulse_cnt(pulse_cnt), .width_err_cnt(width_err_cnt),
    .period_err_cnt(period_err_cnt), .ovf(ovf)
  );

  pulse_measure #(.CNT_W(8), .ERR_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .clr(clr_b), .pulse_in(pulse_b),
    .exp_width(exp_width_b), .exp_period(exp_period_b), .tol(tol_b),
    .width_out(width_out_b), .width_vld(width_vld_b),
    .period_out(period_out_b), .period_vld(period_vld_b),
    .width_err(width_err_b), .period_err(period_err_b),
    .pulse_cnt(pulse_cnt_b), .width_err_cnt(width_err_cnt_b),
    .period_err_cnt(period_err_cnt_b), .ovf(ovf_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // ---------------- reference model (timestamps, not counters) -------------
  longint m_t = 0, m_rise_t = 0;
  bit     m_armed = 0, m_prev = 1, m_have_rise = 0;
  logic [31:0] m_wout = 0, m_pout = 0, m_pcnt = 0;
  bit     m_wvld = 0, m_pvld = 0, m_werr = 0, m_perr = 0;
  int     m_wec = 0, m_pec = 0;

  function automatic bit m_bad(longint meas, longint e, longint t);
    longint d;
    d = meas - e;
    if (d < 0) d = -d;
    return (e != 0) && (d > t);
  endfunction

  always @(posedge clk) begin
    if (rst || clr) begin
      m_armed = 0; m_prev = 1; m_have_rise = 0;
      m_wout = 0; m_pout = 0; m_pcnt = 0;
      m_wvld = 0; m_pvld = 0; m_werr = 0; m_perr = 0;
      m_wec = 0; m_pec = 0;
    end else begin
      if (m_wvld && m_werr && m_wec < 65535) m_wec++;
      if (m_pvld && m_perr && m_pec < 65535) m_pec++;
      m_wvld = 0; m_pvld = 0;
      if (!m_armed) begin
        if (!pulse_in) m_armed = 1;
      end else if (pulse_in && !m_prev) begin
        m_pcnt = m_pcnt + 1;
        if (m_have_rise) begin
          m_pout = 32'(m_t - m_rise_t);
          m_pvld = 1;
          m_perr = m_bad(m_t - m_rise_t, exp_period, tol);
        end
        m_have_rise = 1;
        m_rise_t = m_t;
      end else if (!pulse_in && m_prev && m_have_rise) begin
        m_wout = 32'(m_t - m_rise_t);
        m_wvld = 1;
        m_werr = m_bad(m_t - m_rise_t, exp_width, tol);
      end
      m_prev = pulse_in;
    end
    m_t++;
  end

  // ---------------- helpers ------------------------------------------------
  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // One clock: outputs are compared 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (mon_en) begin
      n_cmp++;
      if (width_out !== m_wout || width_vld !== m_wvld || period_out !== m_pout ||
          period_vld !== m_pvld || width_err !== m_werr || period_err !== m_perr ||
          pulse_cnt !== m_pcnt || width_err_cnt !== 16'(m_wec) ||
          period_err_cnt !== 16'(m_pec) || ovf !== 1'b0) begin
        n_err++;
        $display("FAIL model t=%0d: got w=%0d/%0b/%0b p=%0d/%0b/%0b n=%0d ec=%0d/%0d ovf=%0b, expected w=%0d/%0b/%0b p=%0d/%0b/%0b n=%0d ec=%0d/%0d ovf=0",
                 m_t, width_out, width_vld, width_err, period_out, period_vld, period_err,
                 pulse_cnt, width_err_cnt, period_err_cnt, ovf,
                 m_wout, m_wvld, m_werr, m_pout, m_pvld, m_perr, m_pcnt, m_wec, m_pec);
      end
    end
  endtask

  task automatic drive(input bit lvl, input int n);
    pulse_in = lvl;
    pulse_b  = lvl;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic train(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  // ---------------- vector table -------------------------------------------
  typedef struct {
    int hi, lo, ew, ep, tl;
    int w, p, werr, perr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{hi:256, lo:744, ew:256, ep:1000, tl:0,  w:256, p:1000, werr:0, perr:0};
    vecs[1] = '{hi:256, lo:744, ew:224, ep:1000, tl:31, w:256, p:1000, werr:1, perr:0};
    vecs[2] = '{hi:256, lo:744, ew:224, ep:1000, tl:32, w:256, p:1000, werr:0, perr:0};
    vecs[3] = '{hi:1,   lo:1,   ew:1,   ep:2,    tl:0,  w:1,   p:2,    werr:0, perr:0};
    vecs[4] = '{hi:5,   lo:3,   ew:6,   ep:8,    tl:0,  w:5,   p:8,    werr:1, perr:0};
    vecs[5] = '{hi:5,   lo:3,   ew:0,   ep:10,   tl:1,  w:5,   p:8,    werr:0, perr:1};
    vecs[6] = '{hi:10,  lo:20,  ew:12,  ep:28,   tl:2,  w:10,  p:30,   werr:0, perr:0};
    vecs[7] = '{hi:3,   lo:4,   ew:0,   ep:0,    tl:0,  w:3,   p:7,    werr:0, perr:0};

    rst = 1; clr = 0; pulse_in = 0; exp_width = 0; exp_period = 0; tol = 0;
    rst_b = 1; clr_b = 0; pulse_b = 0; exp_width_b = 0; exp_period_b = 0; tol_b = 0;
    cyc();
    mon_en = 1'b1;
    cyc(); cyc();

    // Reset state
    chk("reset_width_out", width_out, 0);
    chk("reset_period_out", period_out, 0);
    chk("reset_pulse_cnt", pulse_cnt, 0);
    chk("reset_flags", {width_vld, period_vld, width_err, period_err, ovf}, 0);
    rst = 0;

    // Table-driven pulse trains: 3 pulses each, then settle.
    foreach (vecs[k]) begin
      exp_width = 32'(vecs[k].ew); exp_period = 32'(vecs[k].ep); tol = 8'(vecs[k].tl);
      pulse_in = 0;
      pulse_clr();
      drive(1'b0, 2);
      train(vecs[k].hi, vecs[k].lo, 3);
      drive(1'b0, 2);
      chk($sformatf("vec%0d_width", k), width_out, vecs[k].w);
      chk($sformatf("vec%0d_period", k), period_out, vecs[k].p);
      chk($sformatf("vec%0d_werr", k), width_err, vecs[k].werr);
      chk($sformatf("vec%0d_perr", k), period_err, vecs[k].perr);
      chk($sformatf("vec%0d_wecnt", k), width_err_cnt, 3 * vecs[k].werr);
      chk($sformatf("vec%0d_pecnt", k), period_err_cnt, 2 * vecs[k].perr);
      chk($sformatf("vec%0d_pulses", k), pulse_cnt, 3);
    end

    // Pulse high across reset release: partial pulse ignored.
    exp_width = 0; exp_period = 0; tol = 0;
    rst = 1; pulse_in = 1; cyc(); cyc();
    rst = 0;
    drive(1'b1, 4);
    chk("arm_no_count", pulse_cnt, 0);
    drive(1'b0, 3);
    chk("arm_no_width", width_out, 0);
    train(5, 3, 3);
    chk("arm_width", width_out, 5);
    chk("arm_period", period_out, 8);
    chk("arm_pulses", pulse_cnt, 3);

    // clr mid-pulse discards the partial measurement.
    drive(1'b1, 3);
    clr = 1; cyc(); clr = 0;
    chk("clr_outputs", {width_out, period_out, pulse_cnt}, 0);
    drive(1'b1, 3);
    drive(1'b0, 2);
    chk("clr_no_strobe_width", width_out, 0);
    train(4, 2, 1);
    chk("clr_rearm_width", width_out, 4);
    chk("clr_rearm_pulses", pulse_cnt, 1);

    // clr together with rst mid-pulse.
    drive(1'b1, 2);
    clr = 1; rst = 1; cyc(); clr = 0; rst = 0;
    chk("clr_rst_outputs", {width_out, pulse_cnt, width_vld}, 0);
    drive(1'b1, 2);
    drive(1'b0, 2);
    chk("clr_rst_no_strobe", width_out, 0);

    // Randomized pulse trains against the model, with occasional clr.
    for (int n = 0; n < 60; n++) begin
      int hi, lo;
      hi = $urandom_range(1, 12);
      lo = $urandom_range(1, 12);
      exp_width  = 32'($urandom_range(0, 14));
      exp_period = 32'($urandom_range(0, 26));
      tol        = 8'($urandom_range(0, 3));
      for (int c = 0; c < hi + lo; c++) begin
        pulse_in = (c < hi);
        clr = ($urandom_range(0, 59) == 0);
        cyc();
      end
      clr = 0;
    end
    pulse_in = 0;
    drive(1'b0, 2);

    // Instance B: counter saturation, ovf, error-counter saturation.
    rst_b = 0;
    exp_width_b = 8'd3; exp_period_b = 8'd10; tol_b = 8'd0;
    drive(1'b0, 2);
    drive(1'b1, 300);
    drive(1'b0, 2);
    chk("b_sat_width", width_out_b, 255);
    chk("b_ovf_set", ovf_b, 1);
    train(5, 5, 20);
    chk("b_sat_period_err_cnt", period_err_cnt_b, 1);
    chk("b_period_last", period_out_b, 10);
    chk("b_werr_cnt_sat", width_err_cnt_b, 15);
    chk("b_ovf_sticky", ovf_b, 1);
    chk("b_pulses", pulse_cnt_b, 21);
    clr_b = 1; cyc(); clr_b = 0;
    chk("b_clr_ovf", ovf_b, 0);
    chk("b_clr_outputs", {width_out_b, period_out_b, width_err_cnt_b, period_err_cnt_b}, 0);
    chk("b_clr_pulses", pulse_cnt_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
